button_debouncer: RTL

Input-side counterpart to the LED output path: synchronizes, debounces and edge-detects the board push-buttons before they reach `riscv_top`. It runs on the undivided 100 MHz board clock and samples on an internal prescaler tick. It presents stable levels, one-cycle press/release pulses and sticky press flags that the core clears with write-1-to-clear.

---
 rtl/io_pkg.sv | 16 +
 rtl/debounce_channel.sv | 68 ++++++
 rtl/button_debouncer.sv | 70 +++++++
 3 files changed

// File: rtl/io_pkg.sv
// Shared board I/O constants and helpers for the push-button input path.
// The board clock constant is the same one the clock divider uses, so both
// blocks stay in step if the board clock ever changes.
package io_pkg;

   localparam int BOARD_CLOCK_FREQUENCY  = 100_000_000;
   localparam int NUM_BUTTONS            = 5;
   localparam int DEFAULT_SAMPLE_HZ      = 1000;
   localparam int DEFAULT_STABLE_SAMPLES = 8;

   // Number of clock cycles between two debounce samples.
   function automatic int prescale_modulo(input int clock_hz, input int sample_hz);
      return clock_hz / sample_hz;
   endfunction

endpackage

// File: rtl/debounce_channel.sv
// One push-button channel: 2-flop synchronizer, consecutive-sample counter,
// debounced level and registered one-cycle press/release pulses.
module debounce_channel
   import io_pkg::*;
#(
   parameter int STABLE_SAMPLES = DEFAULT_STABLE_SAMPLES
) (
   input  logic CLK,
   input  logic RST,
   input  logic tick,
   input  logic btn_raw,
   output logic level,
   output logic press,
   output logic rel
);

   localparam int              CW         = $clog2(STABLE_SAMPLES + 1);
   localparam logic [CW-1:0]   LAST_COUNT = CW'(STABLE_SAMPLES - 1);

   logic          sync1_reg;
   logic          sync2_reg;
   logic [CW-1:0] count_reg;
   logic          level_reg;
   logic          press_reg;
   logic          rel_reg;

   // Bring the asynchronous button level into the clock domain.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         sync1_reg <= 1'b0;
         sync2_reg <= 1'b0;
      end else begin
         sync1_reg <= btn_raw;
         sync2_reg <= sync1_reg;
      end
   end

   // Count consecutive disagreeing samples; accept the new level once enough
   // have been seen and emit a single-cycle edge pulse alongside it.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         count_reg <= '0;
         level_reg <= 1'b0;
         press_reg <= 1'b0;
         rel_reg   <= 1'b0;
      end else begin
         press_reg <= 1'b0;
         rel_reg   <= 1'b0;
         if (tick) begin
            if (sync2_reg == level_reg) begin
               count_reg <= '0;
            end else if (count_reg == LAST_COUNT) begin
               level_reg <= sync2_reg;
               count_reg <= '0;
               press_reg <= sync2_reg;
               rel_reg   <= ~sync2_reg;
            end else begin
               count_reg <= count_reg + 1'b1;
            end
         end
      end
   end

   assign level = level_reg;
   assign press = press_reg;
   assign rel   = rel_reg;

endmodule

// File: rtl/button_debouncer.sv
// Board push-button front end: shared sample prescaler, one debounce channel
// per button and sticky write-1-to-clear press flags for the core.
module button_debouncer
   import io_pkg::*;
#(
   parameter int CLOCK_FREQUENCY = BOARD_CLOCK_FREQUENCY,
   parameter int SAMPLE_HZ       = DEFAULT_SAMPLE_HZ,
   parameter int STABLE_SAMPLES  = DEFAULT_STABLE_SAMPLES,
   parameter int WIDTH           = NUM_BUTTONS
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic [WIDTH-1:0] BTN,
   input  logic [WIDTH-1:0] CLR,
   output logic [WIDTH-1:0] STATE,
   output logic [WIDTH-1:0] PRESS,
   output logic [WIDTH-1:0] RELEASE,
   output logic [WIDTH-1:0] LATCH
);

   localparam int            MODULO     = prescale_modulo(CLOCK_FREQUENCY, SAMPLE_HZ);
   localparam int            PW         = $clog2(MODULO);
   localparam logic [PW-1:0] LAST_PHASE = PW'(MODULO - 1);

   logic [PW-1:0]    phase_reg;
   logic             tick;
   logic [WIDTH-1:0] latch_reg;

   // Sample strobe in the last cycle of each prescaler period.
   assign tick = (phase_reg == LAST_PHASE);

   // Free-running prescaler shared by every channel.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         phase_reg <= '0;
      end else if (tick) begin
         phase_reg <= '0;
      end else begin
         phase_reg <= phase_reg + 1'b1;
      end
   end

   // Sticky press flags: a press in the same cycle as a clear keeps the flag set.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         latch_reg <= '0;
      end else begin
         latch_reg <= (latch_reg & ~CLR) | PRESS;
      end
   end

   assign LATCH = latch_reg;

   generate
      for (genvar gi = 0; gi < WIDTH; gi++) begin : g_chan
         debounce_channel #(
            .STABLE_SAMPLES(STABLE_SAMPLES)
         ) u_chan (
            .CLK     (CLK),
            .RST     (RST),
            .tick    (tick),
            .btn_raw (BTN[gi]),
            .level   (STATE[gi]),
            .press   (PRESS[gi]),
            .rel     (RELEASE[gi])
         );
      end
   endgenerate

endmodule
